// File: rtl/obstacle_spawner_if.sv
// Spawn request channel between the spawner (slave side drives spawn_o/rand_o) and its environment.
// Pure wiring, no latency; busy_i is the backpressure that holds a pending request.
interface obstacle_spawner_if;
    logic       next_frame_i;
    logic       run_i;
    logic       busy_i;
    logic [1:0] level_i;
    logic       spawn_o;
    logic [1:0] rand_o;

    modport master (
        output next_frame_i, run_i, busy_i, level_i,
        input  spawn_o, rand_o
    );

    modport slave (
        input  next_frame_i, run_i, busy_i, level_i,
        output spawn_o, rand_o
    );
endinterface

// File: rtl/obstacle_spawner.sv
// Obstacle spawn producer: counts frame gaps, then raises a registered request with a random sprite.
// Request rises 1 clk after the gap-ending strobe; held (rand stable) while busy_i blocks acceptance.
module obstacle_spawner #(
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          INIT_GAP   = 60,
    parameter int          BASE_GAP   = 40,
    parameter int          LEVEL_STEP = 8,
    parameter int          MIN_GAP    = 20
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    obstacle_spawner_if.slave  sp
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [15:0] MASK     = 16'hB400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        REQ  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  gap_q, gap_d;
    logic [15:0] lfsr_q;
    logic        spawn_q, spawn_d;
    logic [1:0]  rand_q, rand_d;

    logic [8:0]  raw_gap;
    logic [8:0]  sub_gap;
    logic [8:0]  floor_gap;
    logic [7:0]  reload_gap;

    // Free-running Galois LFSR; an all-zero value would lock up, so fall back to the seed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= SEED_EFF;
        end else if (lfsr_q == 16'h0000) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? MASK : 16'h0000);
        end
    end

    // Widest case is 40 + 63 = 103, so 9 bits never overflow and the result fits 8 bits.
    always_comb begin
        raw_gap    = 9'(BASE_GAP) + {3'b000, lfsr_q[5:0]};
        sub_gap    = 9'(LEVEL_STEP) * {7'b0000000, sp.level_i};
        floor_gap  = sub_gap + 9'(MIN_GAP);
        reload_gap = (raw_gap < floor_gap) ? 8'(MIN_GAP) : 8'(raw_gap - sub_gap);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gap_q   <= 8'(INIT_GAP);
            spawn_q <= 1'b0;
            rand_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            spawn_q <= spawn_d;
            rand_q  <= rand_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        spawn_d = spawn_q;
        rand_d  = rand_q;
        if (!sp.run_i) begin
            // Stopping drops any pending request; rand is left as-is.
            state_d = IDLE;
            spawn_d = 1'b0;
            gap_d   = 8'(INIT_GAP);
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT;
                end
                WAIT: begin
                    if (sp.next_frame_i) begin
                        if (gap_q <= 8'd1) begin
                            state_d = REQ;
                            spawn_d = 1'b1;
                            rand_d  = lfsr_q[1:0];
                            gap_d   = 8'd0;
                        end else begin
                            gap_d = gap_q - 8'd1;
                        end
                    end
                end
                REQ: begin
                    if (sp.next_frame_i && !sp.busy_i) begin
                        state_d = WAIT;
                        spawn_d = 1'b0;
                        gap_d   = reload_gap;
                    end
                end
                default: begin
                    state_d = IDLE;
                    spawn_d = 1'b0;
                end
            endcase
        end
    end

    assign sp.spawn_o = spawn_q;
    assign sp.rand_o  = rand_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Bench for obstacle_spawner: directed frame strobes, expected request edges queued by the stimulus
// and checked by an independent edge monitor; a SEED=0 instance free-runs for sprite coverage.
module tb_obstacle_spawner;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;

    obstacle_spawner_if sif ();
    obstacle_spawner_if sif0 ();

    obstacle_spawner dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .sp     (sif)
    );

    obstacle_spawner #(.SEED(16'h0000)) dut0 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .sp     (sif0)
    );

    typedef struct {
        bit         rise;
        int         at;
        logic [1:0] r;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] m_lfsr;
    logic [1:0]  exp_rand;
    logic        prev_sp;
    logic [1:0]  prev_rand;
    logic        p0;
    int          sp0_cnt;
    logic [3:0]  seen0;
    logic        zero0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR: x16 Galois, taps B400, shifting right.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int reload_f(input logic [15:0] l, input int lvl);
        int raw;
        int sub;
        raw = 40 + int'(l[5:0]);
        sub = lvl * 8;
        return (raw < sub + 20) ? 20 : raw - sub;
    endfunction

    // Edge monitor: every spawn_o edge must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_sp = 1'b0;
        end else begin
            if (sif.spawn_o != prev_sp) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_edge", int'(sif.spawn_o), int'(prev_sp));
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("edge_kind", int'(sif.spawn_o), int'(e.rise));
                    chk("edge_cycle", cyc, e.at);
                    if (e.rise) chk("rand_at_rise", int'(sif.rand_o), int'(e.r));
                end
            end else if (sif.spawn_o) begin
                chk("rand_stable", int'(sif.rand_o), int'(prev_rand));
            end
            prev_sp   = sif.spawn_o;
            prev_rand = sif.rand_o;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (sif0.spawn_o && !p0) begin
                sp0_cnt++;
                seen0[sif0.rand_o] = 1'b1;
            end
            p0 = sif0.spawn_o;
            if (dut0.lfsr_q == 16'h0000) zero0 = 1'b1;
        end else begin
            p0 = 1'b0;
        end
    end

    assign sif0.next_frame_i = 1'b1;
    assign sif0.run_i        = 1'b1;
    assign sif0.busy_i       = 1'b0;
    assign sif0.level_i      = 2'd3;

    task automatic strobes(input int n, input bit push_rise);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sif.next_frame_i = 1'b1;
            if (push_rise && i == n - 1) begin
                exp_rand = m_lfsr[1:0];
                sbq.push_back('{1'b1, cyc + 1, m_lfsr[1:0]});
            end
            @(posedge clk);
            #1 sif.next_frame_i = 1'b0;
        end
    endtask

    // Accepting strobe; want >= 0 delays it until the LFSR's low 6 bits equal want.
    task automatic accept(input int want, output int rl);
        int k;
        k = 0;
        @(negedge clk);
        while (want >= 0 && int'(m_lfsr[5:0]) != want && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 5000) chk("lfsr_wait_timeout", k, 0);
        sif.busy_i       = 1'b0;
        sif.next_frame_i = 1'b1;
        rl = reload_f(m_lfsr, int'(sif.level_i));
        sbq.push_back('{1'b0, cyc + 1, 2'b00});
        @(posedge clk);
        #1 sif.next_frame_i = 1'b0;
    endtask

    initial begin
        int rl;
        int k;
        total = 0; bad = 0; sp0_cnt = 0; seen0 = 4'h0; zero0 = 1'b0;
        p0 = 1'b0; prev_sp = 1'b0; prev_rand = 2'b00; exp_rand = 2'b00;
        rst_n = 1'b0;
        sif.next_frame_i = 1'b0; sif.run_i = 1'b0; sif.busy_i = 1'b0; sif.level_i = 2'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_spawn", int'(sif.spawn_o), 0);
        chk("rst_rand", int'(sif.rand_o), 0);
        chk("rst_gap", int'(dut.gap_q), 60);
        chk("rst_lfsr", int'(dut.lfsr_q), 16'hACE1);
        chk("rst_lfsr_seed0", int'(dut0.lfsr_q), 16'hACE1);

        @(negedge clk);
        rst_n = 1'b1;
        sif.run_i = 1'b1;
        @(posedge clk);
        strobes(60, 1'b1);
        accept(-1, rl);
        chk("gap_after_first_accept", int'(dut.gap_q), rl);

        strobes(rl, 1'b1);
        sif.busy_i = 1'b1;
        strobes(5, 1'b0);
        chk("busy_hold_spawn", int'(sif.spawn_o), 1);
        accept(-1, rl);
        chk("gap_after_busy_accept", int'(dut.gap_q), rl);

        sif.level_i = 2'd3;
        strobes(rl, 1'b1);
        accept(3, rl);
        chk("floor_gap", int'(dut.gap_q), 20);
        strobes(20, 1'b1);
        accept(10, rl);
        chk("level3_gap", int'(dut.gap_q), 26);
        strobes(26, 1'b1);

        @(negedge clk);
        sif.run_i = 1'b0;
        sbq.push_back('{1'b0, cyc + 1, 2'b00});
        @(posedge clk);
        #1;
        chk("stop_req_spawn", int'(sif.spawn_o), 0);
        chk("stop_req_gap", int'(dut.gap_q), 60);
        chk("stop_req_rand_held", int'(sif.rand_o), int'(exp_rand));

        @(negedge clk);
        sif.run_i = 1'b1;
        @(posedge clk);
        strobes(43, 1'b0);
        chk("wait_gap_17", int'(dut.gap_q), 17);
        @(negedge clk);
        sif.run_i = 1'b0;
        @(posedge clk);
        #1;
        chk("stop_wait_gap", int'(dut.gap_q), 60);
        chk("stop_wait_spawn", int'(sif.spawn_o), 0);
        @(negedge clk);
        sif.run_i = 1'b1;
        @(posedge clk);
        strobes(60, 1'b1);

        @(posedge clk);
        #3;
        chk("req_before_reset", int'(sif.spawn_o), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_spawn", int'(sif.spawn_o), 0);
        chk("async_rst_rand", int'(sif.rand_o), 0);
        chk("async_rst_gap", int'(dut.gap_q), 60);
        chk("async_rst_lfsr", int'(dut.lfsr_q), 16'hACE1);
        chk("async_rst_lfsr_seed0", int'(dut0.lfsr_q), 16'hACE1);
        @(posedge clk);
        #3 rst_n = 1'b1;

        k = 0;
        while (sp0_cnt < 200 && k < 30000) begin
            @(posedge clk);
            k++;
        end
        chk("seed0_spawn_count_reached", int'(sp0_cnt >= 200), 1);
        chk("seed0_rand_coverage", int'(seen0), 4'hF);
        chk("seed0_lfsr_never_zero", int'(zero0), 0);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
